// File: rtl/satswarmv2_pkg.sv
// Shared types for the clause broadcast fabric: packet layout, canonical
// binary-clause pair and the helper that puts a pair into canonical order.
package satswarmv2_pkg;

   localparam int PKG_NUM_CORES = 4;
   localparam int PKG_LIT_W     = 32;
   localparam int PKG_SRC_W     = (PKG_NUM_CORES > 1) ? $clog2(PKG_NUM_CORES) : 1;

   typedef struct packed {
      logic [PKG_SRC_W-1:0]        src_core;
      logic signed [PKG_LIT_W-1:0] lit0;
      logic signed [PKG_LIT_W-1:0] lit1;
   } shared_packet_t;

   typedef struct packed {
      logic signed [PKG_LIT_W-1:0] lo;
      logic signed [PKG_LIT_W-1:0] hi;
   } canon_pair_t;

   // Signed ordering makes (a,b) and (b,a) the same history key.
   function automatic canon_pair_t canon_binary(input logic signed [PKG_LIT_W-1:0] lit_a,
                                                input logic signed [PKG_LIT_W-1:0] lit_b);
      canon_pair_t p;
      if (lit_a <= lit_b) begin
         p.lo = lit_a;
         p.hi = lit_b;
      end else begin
         p.lo = lit_b;
         p.hi = lit_a;
      end
      return p;
   endfunction

endpackage

// File: rtl/import_fifo.sv
// Circular-buffer import queue with an occupancy counter; a push is taken
// while full when a pop happens in the same cycle.
module import_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push_valid,
   input  logic [WIDTH-1:0]           push_data,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       pop_ready,
   output logic [WIDTH-1:0]           pop_data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             not_empty, do_push, do_pop;

   assign not_empty = (count_q != '0);
   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign do_pop    = not_empty && pop_ready;
   assign do_push   = push_valid && (!full || do_pop);
   assign count     = count_q;
   assign pop_data  = not_empty ? mem_q[rd_ptr_q] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/clause_import_receiver.sv
// Per-core receive end of the clause broadcast: capture, classify against
// filters and a small history CAM, queue survivors for the local core.
module clause_import_receiver
   import satswarmv2_pkg::*;
#(
   parameter int NUM_CORES  = PKG_NUM_CORES,
   parameter int CORE_ID    = 0,
   parameter int LIT_W      = PKG_LIT_W,
   parameter int FIFO_DEPTH = 16,
   parameter int HIST_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bcast_valid,
   input  shared_packet_t   bcast_payload,
   input  logic             import_en,
   input  logic             flush,
   output logic             imp_valid,
   input  logic             imp_ready,
   output logic [LIT_W-1:0] imp_lit0,
   output logic [LIT_W-1:0] imp_lit1,
   output logic [CNT_W-1:0] stat_rx,
   output logic [CNT_W-1:0] stat_accept,
   output logic [CNT_W-1:0] stat_drop_filter,
   output logic [CNT_W-1:0] stat_drop_dup,
   output logic [CNT_W-1:0] stat_drop_full
);

   localparam int SRC_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int HP_W   = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
   localparam int QC_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int N_STAT = 5;

   logic             s1_valid_q;
   shared_packet_t   s1_pkt_q;
   canon_pair_t      s2_pair, head_pair;
   logic [SRC_W-1:0] s2_src;
   logic             s2_bad, q_full, q_deq;
   logic [QC_W-1:0]  q_count;
   logic             ev_rx, ev_filter, ev_dup, ev_full, ev_accept;

   canon_pair_t           hist_pair_q [HIST_DEPTH];
   logic [HIST_DEPTH-1:0] hist_vld_q;
   logic [HIST_DEPTH-1:0] hist_hit;
   logic [HP_W-1:0]       hist_ptr_q;

   logic [N_STAT-1:0] stat_ev;
   logic [CNT_W-1:0]  stat_q [N_STAT];

   // A beat landing in the flush cycle is dropped before it is ever counted.
   assign ev_rx = bcast_valid && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_pkt_q   <= '0;
      end else begin
         s1_valid_q <= ev_rx;
         if (ev_rx) s1_pkt_q <= bcast_payload;
      end
   end

   assign s2_pair = canon_binary(s1_pkt_q.lit0, s1_pkt_q.lit1);
   assign s2_src  = s1_pkt_q.src_core;
   assign s2_bad  = !import_en || (s2_src == SRC_W'(CORE_ID)) ||
                    (s2_pair.lo == '0) || (s2_pair.hi == '0) ||
                    ((s2_pair.lo + s2_pair.hi) == '0);

   for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist_cmp
      assign hist_hit[gi] = hist_vld_q[gi] && (hist_pair_q[gi] == s2_pair);
   end

   assign q_deq = imp_valid && imp_ready;

   always_comb begin
      ev_filter = 1'b0;
      ev_dup    = 1'b0;
      ev_full   = 1'b0;
      ev_accept = 1'b0;
      if (s1_valid_q && !flush) begin
         if (s2_bad)                  ev_filter = 1'b1;
         else if (|hist_hit)          ev_dup    = 1'b1;
         else if (q_full && !q_deq)   ev_full   = 1'b1;
         else                         ev_accept = 1'b1;
      end
   end

   // History is written on the accept edge so the very next beat sees it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_vld_q <= '0;
         hist_ptr_q <= '0;
      end else if (flush) begin
         hist_vld_q <= '0;
         hist_ptr_q <= '0;
      end else if (ev_accept) begin
         hist_vld_q[hist_ptr_q] <= 1'b1;
         hist_ptr_q <= (hist_ptr_q == HP_W'(HIST_DEPTH - 1)) ? '0 : hist_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ev_accept) hist_pair_q[hist_ptr_q] <= s2_pair;
   end

   import_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(canon_pair_t))
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .push_valid (ev_accept),
      .push_data  (s2_pair),
      .full       (q_full),
      .count      (q_count),
      .pop_ready  (imp_ready),
      .pop_data   (head_pair)
   );

   assign imp_valid = (q_count != '0);
   assign imp_lit0  = head_pair.lo;
   assign imp_lit1  = head_pair.hi;

   assign stat_ev = {ev_full, ev_dup, ev_filter, ev_accept, ev_rx};

   for (genvar gi = 0; gi < N_STAT; gi++) begin : g_stat
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                                  stat_q[gi] <= '0;
         else if (stat_ev[gi] && (stat_q[gi] != '1))  stat_q[gi] <= stat_q[gi] + 1'b1;
      end
   end

   assign stat_rx          = stat_q[0];
   assign stat_accept      = stat_q[1];
   assign stat_drop_filter = stat_q[2];
   assign stat_drop_dup    = stat_q[3];
   assign stat_drop_full   = stat_q[4];

endmodule

// File: tb/tb_clause_import_receiver.sv
// Bench for clause_import_receiver: directed table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_clause_import_receiver;
   import satswarmv2_pkg::*;

   localparam int CORE_ID    = 0;
   localparam int FIFO_DEPTH = 16;
   localparam int HIST_DEPTH = 8;
   localparam int CNT_W      = 16;
   localparam longint MAXC   = (64'd1 << CNT_W) - 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           bcast_valid = 1'b0;
   shared_packet_t bcast_payload = '0;
   logic           import_en = 1'b1;
   logic           flush = 1'b0;
   logic           imp_ready = 1'b0;
   logic           imp_valid;
   logic [31:0]    imp_lit0, imp_lit1;
   logic [15:0]    stat_rx, stat_accept, stat_drop_filter, stat_drop_dup, stat_drop_full;

   clause_import_receiver #(
      .NUM_CORES(4), .CORE_ID(CORE_ID), .LIT_W(32),
      .FIFO_DEPTH(FIFO_DEPTH), .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bcast_valid(bcast_valid), .bcast_payload(bcast_payload),
      .import_en(import_en), .flush(flush), .imp_valid(imp_valid), .imp_ready(imp_ready),
      .imp_lit0(imp_lit0), .imp_lit1(imp_lit1), .stat_rx(stat_rx), .stat_accept(stat_accept),
      .stat_drop_filter(stat_drop_filter), .stat_drop_dup(stat_drop_dup),
      .stat_drop_full(stat_drop_full)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference model: the import queue and the recent-accept history as plain
   // queues, classification written straight from the drop rules.
   typedef struct { int lo; int hi; } pair_t;
   pair_t  mq[$];
   pair_t  mh[$];
   bit     m_s1_v;
   int     m_s1_src, m_s1_a, m_s1_b;
   longint m_rx, m_acc, m_filt, m_dup, m_full;

   function automatic longint bump(input longint x);
      return (x >= MAXC) ? MAXC : x + 1;
   endfunction

   function automatic void model_reset();
      mq.delete(); mh.delete();
      m_s1_v = 0; m_s1_src = 0; m_s1_a = 0; m_s1_b = 0;
      m_rx = 0; m_acc = 0; m_filt = 0; m_dup = 0; m_full = 0;
   endfunction

   function automatic void model_step(input bit v, input int src, input int a, input int b,
                                      input bit en, input bit fl, input bit rdy);
      bit    deq, hit;
      pair_t p;
      deq = (mq.size() != 0) && rdy;
      if (fl) begin
         mq.delete(); mh.delete(); m_s1_v = 0;
         return;
      end
      if (m_s1_v) begin
         p.lo = (m_s1_a < m_s1_b) ? m_s1_a : m_s1_b;
         p.hi = (m_s1_a < m_s1_b) ? m_s1_b : m_s1_a;
         hit = 0;
         foreach (mh[i]) if (mh[i].lo == p.lo && mh[i].hi == p.hi) hit = 1;
         if (!en || m_s1_src == CORE_ID || p.lo == 0 || p.hi == 0 || p.lo == -p.hi)
            m_filt = bump(m_filt);
         else if (hit)
            m_dup = bump(m_dup);
         else if (mq.size() == FIFO_DEPTH && !deq)
            m_full = bump(m_full);
         else begin
            mq.push_back(p);
            mh.push_back(p);
            if (mh.size() > HIST_DEPTH) void'(mh.pop_front());
            m_acc = bump(m_acc);
         end
      end
      if (deq) void'(mq.pop_front());
      m_s1_v = v; m_s1_src = src; m_s1_a = a; m_s1_b = b;
      if (v) m_rx = bump(m_rx);
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ".imp_valid"}, longint'(imp_valid), longint'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk({tag, ".imp_lit0"}, longint'($signed(imp_lit0)), longint'(mq[0].lo));
         chk({tag, ".imp_lit1"}, longint'($signed(imp_lit1)), longint'(mq[0].hi));
      end
      chk({tag, ".stat_rx"},          longint'(stat_rx),          m_rx);
      chk({tag, ".stat_accept"},      longint'(stat_accept),      m_acc);
      chk({tag, ".stat_drop_filter"}, longint'(stat_drop_filter), m_filt);
      chk({tag, ".stat_drop_dup"},    longint'(stat_drop_dup),    m_dup);
      chk({tag, ".stat_drop_full"},   longint'(stat_drop_full),   m_full);
   endtask

   // Drive at the negedge, let the posedge act, return at the next negedge.
   task automatic cycle(input bit v, input int src, input int a, input int b,
                        input bit en, input bit fl, input bit rdy);
      bcast_valid            = v;
      bcast_payload.src_core = PKG_SRC_W'(src);
      bcast_payload.lit0     = a;
      bcast_payload.lit1     = b;
      import_en              = en;
      flush                  = fl;
      imp_ready              = rdy;
      @(posedge clk);
      model_step(v, src, a, b, en, fl, rdy);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 1, 0, rdy);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".imp_valid"},   longint'(imp_valid), 0);
      chk({tag, ".imp_lit0"},    longint'(imp_lit0), 0);
      chk({tag, ".imp_lit1"},    longint'(imp_lit1), 0);
      chk({tag, ".stat_rx"},     longint'(stat_rx), 0);
      chk({tag, ".stat_accept"}, longint'(stat_accept), 0);
      chk({tag, ".stat_drops"},  longint'(stat_drop_filter) + longint'(stat_drop_dup) +
                                 longint'(stat_drop_full), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bcast_valid = 1'b0; flush = 1'b0; imp_ready = 1'b0; import_en = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit v; int src; int a; int b; bit en; bit rdy;
      bit e_valid; int e_lo; int e_hi; int e_rx; int e_acc; int e_filt;
   } vec_t;

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t tbl[7];
      int   drained, last_lo, last_hi;

      // Basic accept followed by the four filter causes (import_en checked at S2).
      tbl[0] = '{1, 2,  5, -3, 1, 1,  0,  0, 0,  1, 0, 0};
      tbl[1] = '{0, 0,  0,  0, 1, 1,  1, -3, 5,  1, 1, 0};
      tbl[2] = '{1, 0,  1,  2, 1, 1,  0,  0, 0,  2, 1, 0};
      tbl[3] = '{1, 1,  0,  4, 1, 1,  0,  0, 0,  3, 1, 1};
      tbl[4] = '{1, 1,  7, -7, 1, 1,  0,  0, 0,  4, 1, 2};
      tbl[5] = '{1, 1,  3,  6, 1, 1,  0,  0, 0,  5, 1, 3};
      tbl[6] = '{0, 0,  0,  0, 0, 1,  0,  0, 0,  5, 1, 4};

      do_reset();
      @(negedge clk);
      foreach (tbl[i]) begin
         cycle(tbl[i].v, tbl[i].src, tbl[i].a, tbl[i].b, tbl[i].en, 1'b0, tbl[i].rdy);
         $display("vec %0d: beat=%0b src=%0d (%0d,%0d) en=%0b -> imp_valid=%0b rx=%0d acc=%0d filt=%0d",
                  i, tbl[i].v, tbl[i].src, tbl[i].a, tbl[i].b, tbl[i].en, imp_valid,
                  stat_rx, stat_accept, stat_drop_filter);
         chk($sformatf("vec%0d.imp_valid", i), longint'(imp_valid), longint'(tbl[i].e_valid));
         if (tbl[i].e_valid) begin
            chk($sformatf("vec%0d.imp_lit0", i), longint'($signed(imp_lit0)), longint'(tbl[i].e_lo));
            chk($sformatf("vec%0d.imp_lit1", i), longint'($signed(imp_lit1)), longint'(tbl[i].e_hi));
         end
         chk($sformatf("vec%0d.stat_rx", i),     longint'(stat_rx),          longint'(tbl[i].e_rx));
         chk($sformatf("vec%0d.stat_accept", i), longint'(stat_accept),      longint'(tbl[i].e_acc));
         chk($sformatf("vec%0d.stat_filter", i), longint'(stat_drop_filter), longint'(tbl[i].e_filt));
      end
      check_model("vec_end");

      // Dedup: reversed and repeated pairs back-to-back, then history eviction.
      do_reset();
      @(negedge clk);
      cycle(1, 1, 1, 2, 1, 0, 1);
      cycle(1, 1, 2, 1, 1, 0, 1);
      cycle(1, 1, 1, 2, 1, 0, 1);
      idle(2, 1);
      $display("dedup: acc=%0d dup=%0d", stat_accept, stat_drop_dup);
      chk("dedup.accept", longint'(stat_accept), 1);
      chk("dedup.dup", longint'(stat_drop_dup), 2);
      for (int i = 0; i < HIST_DEPTH; i++) cycle(1, 1, 10 + i, 20 + i, 1, 0, 1);
      cycle(1, 1, 1, 2, 1, 0, 1);
      idle(2, 1);
      $display("dedup evict: acc=%0d dup=%0d", stat_accept, stat_drop_dup);
      chk("evict.accept", longint'(stat_accept), 10);
      chk("evict.dup", longint'(stat_drop_dup), 2);
      check_model("dedup");

      // Overflow: 20 beats into a stalled 16-deep queue, then ordered drain.
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 20; i++) cycle(1, 2, 100 + i, 200 + i, 1, 0, 0);
      idle(2, 0);
      $display("overflow: acc=%0d full=%0d", stat_accept, stat_drop_full);
      chk("ovf.accept", longint'(stat_accept), 16);
      chk("ovf.full", longint'(stat_drop_full), 4);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("drain%0d.valid", k), longint'(imp_valid), 1);
         chk($sformatf("drain%0d.lit0", k), longint'($signed(imp_lit0)), longint'(100 + k));
         chk($sformatf("drain%0d.lit1", k), longint'($signed(imp_lit1)), longint'(200 + k));
         cycle(0, 1, 0, 0, 1, 0, 1);
      end
      chk("drain.empty", longint'(imp_valid), 0);
      check_model("overflow");

      // Full queue with a dequeue in the same cycle as a new S2 beat.
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 16; i++) cycle(1, 3, 300 + i, 400 + i, 1, 0, 0);
      idle(2, 0);
      cycle(1, 3, 600, 500, 1, 0, 0);
      cycle(0, 1, 0, 0, 1, 0, 1);
      $display("full+deq: acc=%0d full=%0d", stat_accept, stat_drop_full);
      chk("fulldeq.accept", longint'(stat_accept), 17);
      chk("fulldeq.full", longint'(stat_drop_full), 0);
      drained = 0; last_lo = 0; last_hi = 0;
      while (imp_valid && drained < 20) begin
         last_lo = $signed(imp_lit0);
         last_hi = $signed(imp_lit1);
         cycle(0, 1, 0, 0, 1, 0, 1);
         drained++;
      end
      $display("full+deq: drained=%0d last=(%0d,%0d)", drained, last_lo, last_hi);
      chk("fulldeq.occupancy", longint'(drained), 16);
      chk("fulldeq.last_lo", longint'(last_lo), 500);
      chk("fulldeq.last_hi", longint'(last_hi), 600);

      // Flush with 5 queued and a beat arriving in the flush cycle.
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 5; i++) cycle(1, 1, 700 + i, 800 + i, 1, 0, 0);
      idle(2, 0);
      cycle(1, 1, 900, 901, 1, 1, 0);
      $display("flush: imp_valid=%0b rx=%0d acc=%0d", imp_valid, stat_rx, stat_accept);
      chk("flush.imp_valid", longint'(imp_valid), 0);
      chk("flush.rx", longint'(stat_rx), 5);
      chk("flush.accept", longint'(stat_accept), 5);
      cycle(1, 1, 800, 700, 1, 0, 0);
      idle(2, 0);
      chk("reaccept.accept", longint'(stat_accept), 6);
      chk("reaccept.dup", longint'(stat_drop_dup), 0);
      chk("reaccept.lit0", longint'($signed(imp_lit0)), 700);
      check_model("flush");

      // Asynchronous reset in the middle of traffic.
      for (int i = 0; i < 3; i++) cycle(1, 2, 40 + i, 50 + i, 1, 0, 0);
      bcast_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      $display("async reset: imp_valid=%0b rx=%0d", imp_valid, stat_rx);
      check_zero("async_rst");
      model_reset();
      bcast_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic: small literal range forces dups and filters,
      // stalled phases force full drops, occasional flushes.
      @(negedge clk);
      for (int i = 0; i < 800; i++) begin
         bit r_v, r_en, r_fl, r_rdy;
         int r_src, r_a, r_b;
         r_v   = ($urandom_range(0, 3) != 0);
         r_src = $urandom_range(0, 3);
         r_a   = int'($urandom_range(0, 10)) - 5;
         r_b   = int'($urandom_range(0, 10)) - 5;
         r_en  = ($urandom_range(0, 9) != 0);
         r_fl  = ($urandom_range(0, 59) == 0);
         r_rdy = ((i % 200) < 100) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
         cycle(r_v, r_src, r_a, r_b, r_en, r_fl, r_rdy);
         check_model($sformatf("rand%0d", i));
      end
      $display("random: rx=%0d acc=%0d filt=%0d dup=%0d full=%0d",
               stat_rx, stat_accept, stat_drop_filter, stat_drop_dup, stat_drop_full);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
